// File: rtl/hybrid_buffer_slot_array_if.sv
// Write/pop bus between the fetch logic, the driver and the slot array.
// Optional error flag signals are present when HYBRID_BUFFER_ERROR_FLAGS_EN is defined.
interface hybrid_buffer_slot_array_if #(
  parameter int BUFFER_SLOTS = 16,
  parameter int DATA_WIDTH   = 16
);
  localparam int SW = (BUFFER_SLOTS > 1) ? $clog2(BUFFER_SLOTS) : 1;

  logic                                    flush;
  logic                                    write_en;
  logic [SW-1:0]                           write_slot;
  logic [DATA_WIDTH-1:0]                   write_data;
  logic [BUFFER_SLOTS-1:0]                 slot_full;
  logic [BUFFER_SLOTS-1:0]                 slot_empty;
  logic                                    pulse;
  logic [BUFFER_SLOTS-1:0]                 slot_pop_shift;
  logic [BUFFER_SLOTS-1:0][DATA_WIDTH-1:0] slot_data;
  logic [BUFFER_SLOTS-1:0]                 slot_data_valid;
`ifdef HYBRID_BUFFER_ERROR_FLAGS_EN
  logic [BUFFER_SLOTS-1:0]                 overflow_err;
  logic [BUFFER_SLOTS-1:0]                 underflow_err;
`endif

  modport master (
    output flush, write_en, write_slot, write_data, pulse, slot_pop_shift,
    input  slot_full, slot_empty, slot_data, slot_data_valid
`ifdef HYBRID_BUFFER_ERROR_FLAGS_EN
    , input overflow_err, underflow_err
`endif
  );

  modport slave (
    input  flush, write_en, write_slot, write_data, pulse, slot_pop_shift,
    output slot_full, slot_empty, slot_data, slot_data_valid
`ifdef HYBRID_BUFFER_ERROR_FLAGS_EN
    , output overflow_err, underflow_err
`endif
  );
endinterface

// File: rtl/hybrid_buffer_slot_array.sv
// Array of independent per-slot FIFOs popped by a shared pulse and per-slot enables.
// Define HYBRID_BUFFER_ERROR_FLAGS_EN to add sticky overflow/underflow flags.
module hybrid_buffer_slot_array #(
  parameter int BUFFER_SLOTS = 16,
  parameter int SLOT_DEPTH   = 64,
  parameter int DATA_WIDTH   = 16
) (
  input logic                        core_clk,
  input logic                        resetn,
  hybrid_buffer_slot_array_if.slave  bus
);
  localparam int PW = $clog2(SLOT_DEPTH);
  localparam int CW = $clog2(SLOT_DEPTH + 1);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(SLOT_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < BUFFER_SLOTS; gi++) begin : g_slot
      logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
      logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
      logic [CW-1:0]         count_q, count_d;
      logic                  valid_q, valid_d;
      logic [DATA_WIDTH-1:0] data_q;
      logic [DATA_WIDTH-1:0] mem [SLOT_DEPTH];
      logic                  full, empty, wr_hit, pop_req, pop, wr_acc;

      assign full    = (count_q == CW'(SLOT_DEPTH));
      assign empty   = (count_q == '0);
      // Indices beyond the last slot never match any gi, so they are ignored.
      assign wr_hit  = bus.write_en && (32'(bus.write_slot) == gi);
      assign pop_req = bus.pulse && bus.slot_pop_shift[gi];
      assign pop     = pop_req && !empty;
      assign wr_acc  = wr_hit && (!full || pop);

      always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        valid_d  = 1'b0;
        if (!bus.flush) begin
          if (wr_acc) wr_ptr_d = ptr_inc(wr_ptr_q);
          if (pop)    rd_ptr_d = ptr_inc(rd_ptr_q);
          case ({wr_acc, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
          endcase
          valid_d = pop;
        end else begin
          rd_ptr_d = '0;
          wr_ptr_d = '0;
          count_d  = '0;
        end
      end

      always_ff @(posedge core_clk or negedge resetn) begin
        if (!resetn) begin
          rd_ptr_q <= '0;
          wr_ptr_q <= '0;
          count_q  <= '0;
          valid_q  <= 1'b0;
        end else begin
          rd_ptr_q <= rd_ptr_d;
          wr_ptr_q <= wr_ptr_d;
          count_q  <= count_d;
          valid_q  <= valid_d;
        end
      end

      always_ff @(posedge core_clk) begin
        if (wr_acc && !bus.flush) mem[wr_ptr_q] <= bus.write_data;
      end

      // Pop reads the pre-write state, so an empty slot never bypasses the incoming word.
      always_ff @(posedge core_clk or negedge resetn) begin
        if (!resetn)                data_q <= '0;
        else if (pop && !bus.flush) data_q <= mem[rd_ptr_q];
      end

      assign bus.slot_full[gi]       = full;
      assign bus.slot_empty[gi]      = empty;
      assign bus.slot_data[gi]       = data_q;
      assign bus.slot_data_valid[gi] = valid_q;

`ifdef HYBRID_BUFFER_ERROR_FLAGS_EN
      logic ovf_q, ovf_d, udf_q, udf_d;

      always_comb begin
        ovf_d = ovf_q | (wr_hit && full && !pop);
        udf_d = udf_q | (pop_req && empty);
        if (bus.flush) begin
          ovf_d = 1'b0;
          udf_d = 1'b0;
        end
      end

      always_ff @(posedge core_clk or negedge resetn) begin
        if (!resetn) begin
          ovf_q <= 1'b0;
          udf_q <= 1'b0;
        end else begin
          ovf_q <= ovf_d;
          udf_q <= udf_d;
        end
      end

      assign bus.overflow_err[gi]  = ovf_q;
      assign bus.underflow_err[gi] = udf_q;
`endif
    end
  endgenerate
endmodule

// File: tb/tb_hybrid_buffer_slot_array.sv
// Directed bench for hybrid_buffer_slot_array: a vector table plus hand sequences
// for fill/drain, wavefront, write+pop on full, empty pop, flush/wrap and async reset.
module tb_hybrid_buffer_slot_array;
  localparam int NS = 16;
  localparam int DEPTH = 64;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  hybrid_buffer_slot_array_if #(.BUFFER_SLOTS(NS), .DATA_WIDTH(DW)) bus ();

  hybrid_buffer_slot_array #(.BUFFER_SLOTS(NS), .SLOT_DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .core_clk (clk),
    .resetn   (resetn),
    .bus      (bus.slave)
  );

  typedef struct {
    logic        fl;
    logic        we;
    logic [3:0]  ws;
    logic [15:0] wd;
    logic        pl;
    logic [15:0] sh;
    logic [15:0] exp_empty;
    logic [15:0] exp_valid;
    int          chk_slot;
    logic [15:0] exp_data;
  } vec_t;

  vec_t vecs[7];
  int passed = 0;
  int total = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic drive(input logic fl, input logic we, input logic [3:0] ws,
                       input logic [15:0] wd, input logic pl, input logic [15:0] sh);
    @(negedge clk);
    bus.flush          = fl;
    bus.write_en       = we;
    bus.write_slot     = ws;
    bus.write_data     = wd;
    bus.pulse          = pl;
    bus.slot_pop_shift = sh;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] ws, input logic [15:0] wd);
    drive(1'b0, 1'b1, ws, wd, 1'b0, 16'h0);
  endtask

  task automatic pop(input logic [15:0] sh);
    drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b1, sh);
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b1, 4'd1,  16'h1111, 1'b0, 16'h0000, 16'hFFFD, 16'h0000, 1,  16'h0000};
    vecs[1] = '{1'b0, 1'b1, 4'd1,  16'h2222, 1'b1, 16'h0002, 16'hFFFD, 16'h0002, 1,  16'h1111};
    vecs[2] = '{1'b0, 1'b0, 4'd0,  16'h0000, 1'b1, 16'h0006, 16'hFFFF, 16'h0002, 1,  16'h2222};
    vecs[3] = '{1'b0, 1'b1, 4'd1,  16'h3333, 1'b1, 16'h0002, 16'hFFFD, 16'h0000, 1,  16'h2222};
    vecs[4] = '{1'b0, 1'b1, 4'd15, 16'hAAAA, 1'b0, 16'h0000, 16'h7FFD, 16'h0000, 15, 16'h0000};
    vecs[5] = '{1'b0, 1'b0, 4'd0,  16'h0000, 1'b1, 16'h8002, 16'hFFFF, 16'h8002, 15, 16'hAAAA};
    vecs[6] = '{1'b0, 1'b0, 4'd0,  16'h0000, 1'b0, 16'h0000, 16'hFFFF, 16'h0000, 1,  16'h3333};

    resetn = 1'b0;
    bus.flush = 1'b0; bus.write_en = 1'b0; bus.write_slot = '0; bus.write_data = '0;
    bus.pulse = 1'b0; bus.slot_pop_shift = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_empty", bus.slot_empty, 16'hFFFF);
    chk("rst_full", bus.slot_full, 16'h0);
    chk("rst_valid", bus.slot_data_valid, 16'h0);
    chk("rst_data_zero", (bus.slot_data == '0), 1'b1);
    @(negedge clk);
    resetn = 1'b1;

    for (int v = 0; v < 7; v++) begin
      drive(vecs[v].fl, vecs[v].we, vecs[v].ws, vecs[v].wd, vecs[v].pl, vecs[v].sh);
      chk($sformatf("vec%0d_empty", v), bus.slot_empty, vecs[v].exp_empty);
      chk($sformatf("vec%0d_full", v), bus.slot_full, 16'h0);
      chk($sformatf("vec%0d_valid", v), bus.slot_data_valid, vecs[v].exp_valid);
      chk($sformatf("vec%0d_data", v), bus.slot_data[vecs[v].chk_slot], vecs[v].exp_data);
    end

    // Fill and drain slot 0
    for (int k = 0; k < DEPTH; k++) wr(4'd0, 16'h0100 + 16'(k));
    chk("fill_full0", bus.slot_full[0], 1'b1);
    chk("fill_empty0", bus.slot_empty[0], 1'b0);
    wr(4'd0, 16'hDEAD);
    chk("drop_full0", bus.slot_full[0], 1'b1);
`ifdef HYBRID_BUFFER_ERROR_FLAGS_EN
    chk("overflow0", bus.overflow_err, 16'h0001);
`endif
    for (int k = 0; k < DEPTH; k++) begin
      pop(16'h0001);
      chk($sformatf("drain_valid%0d", k), bus.slot_data_valid, 16'h0001);
      chk($sformatf("drain_data%0d", k), bus.slot_data[0], 16'h0100 + 16'(k));
    end
    chk("drain_empty0", bus.slot_empty[0], 1'b1);

    // Diagonal wavefront
    for (int i = 0; i < NS; i++)
      for (int k = 0; k < 4; k++) wr(4'(i), 16'h2000 + 16'(i * 16 + k));
    for (int p = 0; p < 4; p++) begin
      logic [15:0] sh;
      sh = 16'((1 << (p + 1)) - 1);
      pop(sh);
      chk($sformatf("wave_valid%0d", p), bus.slot_data_valid, sh);
      chk($sformatf("wave_data%0d", p), bus.slot_data[p], 16'h2000 + 16'(p * 16));
    end
    chk("wave_data0_last", bus.slot_data[0], 16'h2003);
    drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 16'h0);
    chk("wave_idle_valid", bus.slot_data_valid, 16'h0);
    drive(1'b1, 1'b0, 4'd0, 16'h0, 1'b0, 16'h0);
    chk("wave_flush_empty", bus.slot_empty, 16'hFFFF);
    chk("wave_flush_full", bus.slot_full, 16'h0);
`ifdef HYBRID_BUFFER_ERROR_FLAGS_EN
    chk("flush_clr_ovf", bus.overflow_err, 16'h0);
`endif

    // Simultaneous write and pop on a full slot
    for (int k = 0; k < DEPTH; k++) wr(4'd3, 16'h3000 + 16'(k));
    drive(1'b0, 1'b1, 4'd3, 16'hBEEF, 1'b1, 16'h0008);
    chk("wp_valid", bus.slot_data_valid, 16'h0008);
    chk("wp_data", bus.slot_data[3], 16'h3000);
    chk("wp_full", bus.slot_full[3], 1'b1);
    for (int k = 1; k < DEPTH; k++) begin
      pop(16'h0008);
      chk($sformatf("wp_drain%0d", k), bus.slot_data[3], 16'h3000 + 16'(k));
    end
    pop(16'h0008);
    chk("wp_last_beef", bus.slot_data[3], 16'hBEEF);
    chk("wp_empty", bus.slot_empty[3], 1'b1);
`ifdef HYBRID_BUFFER_ERROR_FLAGS_EN
    chk("wp_no_ovf", bus.overflow_err, 16'h0);
`endif

    // Pop request while every slot is empty
    pop(16'hFFFF);
    chk("ep_valid", bus.slot_data_valid, 16'h0);
    chk("ep_hold3", bus.slot_data[3], 16'hBEEF);
    chk("ep_hold0", bus.slot_data[0], 16'h2003);
`ifdef HYBRID_BUFFER_ERROR_FLAGS_EN
    chk("ep_underflow", bus.underflow_err, 16'hFFFF);
`endif

    // Flush and pointer wrap on slot 5
    for (int k = 0; k < 40; k++) wr(4'd5, 16'h5000 + 16'(k));
    for (int k = 0; k < 30; k++) begin
      pop(16'h0020);
      chk($sformatf("wrap_popA%0d", k), bus.slot_data[5], 16'h5000 + 16'(k));
    end
    for (int k = 40; k < 80; k++) wr(4'd5, 16'h5000 + 16'(k));
    for (int k = 30; k < 80; k++) begin
      pop(16'h0020);
      chk($sformatf("wrap_popB%0d", k), bus.slot_data[5], 16'h5000 + 16'(k));
    end
    chk("wrap_empty", bus.slot_empty[5], 1'b1);
    for (int k = 0; k < 3; k++) wr(4'd5, 16'h5100 + 16'(k));
    chk("wrap_refill", bus.slot_empty[5], 1'b0);
    drive(1'b1, 1'b1, 4'd5, 16'h5555, 1'b1, 16'h0020);
    chk("flush_valid", bus.slot_data_valid, 16'h0);
    chk("flush_empty", bus.slot_empty, 16'hFFFF);
    chk("flush_hold", bus.slot_data[5], 16'h504F);
`ifdef HYBRID_BUFFER_ERROR_FLAGS_EN
    chk("flush_clr_udf", bus.underflow_err, 16'h0);
`endif

    // Asynchronous reset while a pop is in flight
    wr(4'd7, 16'h7000);
    wr(4'd7, 16'h7001);
    pop(16'h0080);
    chk("ar_valid", bus.slot_data_valid, 16'h0080);
    chk("ar_data", bus.slot_data[7], 16'h7000);
    #2;
    resetn = 1'b0;
    #1;
    chk("ar_now_valid", bus.slot_data_valid, 16'h0);
    chk("ar_now_empty", bus.slot_empty, 16'hFFFF);
    chk("ar_now_data", bus.slot_data[7], 16'h0);
    @(posedge clk);
    #1;
    chk("ar_hold_valid", bus.slot_data_valid, 16'h0);
    @(negedge clk);
    resetn = 1'b1;
    bus.pulse = 1'b0;
    bus.slot_pop_shift = '0;
    @(posedge clk);
    #1;
    chk("ar_rel_valid", bus.slot_data_valid, 16'h0);
    chk("ar_rel_empty", bus.slot_empty[7], 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/hybrid_buffer_slot_array.md
# hybrid_buffer_slot_array

Per-slot FIFO storage consumed by `hybrid_buffer_driver`. It holds `BUFFER_SLOTS` independent FIFOs, loaded one word per cycle by the upstream fetch logic. On each `pulse`, every slot whose `slot_pop_shift` bit is set pops one word, which produces the diagonal (skewed) data wavefront that feeds the systolic array.

## Interface
- `BUFFER_SLOTS`, default 16: number of slots. Must match the driver's slot count.
- `SLOT_DEPTH`, default 64: words per slot FIFO. Minimum 2; need not be a power of two.
- `DATA_WIDTH`, default 16: width of each word.
- `core_clk`, input, 1: the block's single clock; all logic is on its rising edge.
- `resetn`, input, 1: reset, asynchronous and active-low.
- `flush`, input, 1: synchronously empties all slots.
- `write_en`, input, 1: write `write_data` into slot `write_slot`.
- `write_slot`, input, `$clog2(BUFFER_SLOTS)`: target slot index.
- `write_data`, input, `DATA_WIDTH`: word to store.
- `slot_full`, output, `BUFFER_SLOTS`: per-slot full flag (count == `SLOT_DEPTH`).
- `slot_empty`, output, `BUFFER_SLOTS`: per-slot empty flag (count == 0).
- `pulse`, input, 1: pop strobe, the same signal that drives the driver.
- `slot_pop_shift`, input, `BUFFER_SLOTS`: per-slot pop enable from the driver.
- `slot_data`, output, `BUFFER_SLOTS` x `DATA_WIDTH`: registered popped word per slot.
- `slot_data_valid`, output, `BUFFER_SLOTS`: a pop happened on the previous cycle.

## Operation
- **Per-slot state:** read pointer, write pointer (each `$clog2(SLOT_DEPTH)` bits) and count (`$clog2(SLOT_DEPTH+1)` bits).
- **Pointer wrap:** a pointer equal to `SLOT_DEPTH-1` wraps to 0 on its next increment.
- **Write accept:** `write_en && !slot_full[write_slot]`. The word is stored at the write pointer, the write pointer advances and the count increments.
- **Write to a full slot:** the word is dropped and no state changes.
- **Write with out-of-range index** (`write_slot >= BUFFER_SLOTS`): ignored.
- **Pop on slot i:** occurs when `pulse && slot_pop_shift[i] && !slot_empty[i]`.
  - The head word is registered into `slot_data[i]`.
  - The read pointer advances and the count decrements.
- **Pop request on an empty slot:** no pop, and `slot_data_valid[i]` is 0 on the next cycle.
- **Simultaneous write and pop on the same slot:** both are performed and the count is unchanged.
  - On a full slot, the pop frees the entry in the same cycle, so the write is accepted.
  - On an empty slot, the write is accepted but the pop is not: pops see the state before the write, so there is no bypass.
- **`slot_data` hold:** `slot_data[i]` keeps its last value when there is no pop.
- **`slot_data_valid` timing:** `slot_data_valid[i]` is 1 for exactly one cycle after each pop.
- **`flush`:** clears all pointers, counts and `slot_data_valid` on the next edge. It has priority over a write or pop in the same cycle. Storage contents are not cleared.
- **Storage:** inferred RAM or register array with no reset. Pointers, counts and output registers are reset.

## Timing
- **Reset values:**
  - `slot_empty` = all ones.
  - `slot_full` = all zeros.
  - `slot_data_valid` = all zeros.
  - `slot_data` = all zeros.
- **Full/empty flags:** combinational from the count, so they reflect an accepted write or pop on the cycle after the edge.
- **Pop latency:** 1 cycle. A `pulse` at edge N gives valid data during cycle N+1.
- **Write-to-pop latency:** a word written at edge N is poppable by a `pulse` sampled at edge N+1.
- **Back-to-back pops:** one pop per slot per cycle is sustained at full rate.
- **Reset mid-operation:** asserting `resetn` low returns all state to the reset values immediately, asynchronously. A pending pop is lost.

## Configuration
- **Macro:** `HYBRID_BUFFER_ERROR_FLAGS_EN`.
- **When defined:** the block adds two outputs, `overflow_err` and `underflow_err`, each `BUFFER_SLOTS` wide.
  - `overflow_err[i]` sets on a dropped write to slot i.
  - `underflow_err[i]` sets on a pop request to an empty slot i.
  - Both are sticky, cleared by reset or `flush`, and reset to 0.
- **When undefined:** these ports and their logic are absent. Drops and empty pops are silently ignored as described above.

## Test plan
- **Fill and drain:**
  - Stimulus: write 0x0100+k to slot 0 for k = 0..63 (`SLOT_DEPTH` = 64).
  - Response: `slot_full[0]` = 1 and a 65th write is dropped.
  - Then 64 pulses with `slot_pop_shift[0]` = 1 return 0x0100..0x013F in order, and `slot_empty[0]` = 1 afterwards.
- **Diagonal wavefront:**
  - Stimulus: preload 4 words in each of 16 slots, then drive `slot_pop_shift` 0x0001, 0x0003, 0x0007 … on successive pulses.
  - Response: `slot_data_valid` follows the same pattern one cycle later.
- **Simultaneous write and pop:**
  - Stimulus: slot 3 is full and gets a write of 0xBEEF plus a pop in the same cycle.
  - Response: the count stays 64, the head word is output, and 0xBEEF is popped last.
- **Empty-pop:**
  - Stimulus: pulse with all `slot_pop_shift` bits set while every slot is empty.
  - Response: `slot_data_valid` = 0 and `slot_data` is unchanged. With the macro, `underflow_err` = 0xFFFF.
- **Flush and wrap:**
  - Stimulus: write 40 words, pop 30, write 40 more to slot 5 (pointers wrap), then assert `flush`.
  - Response: all 50 remaining words are popped in order before the flush. After the flush, `slot_empty[5]` = 1.
- **Async reset mid-pop:**
  - Stimulus: drop `resetn` low between edges while `pulse` is active.
  - Response: all outputs go to their reset values immediately, with no valid pulse after release.
